// File: rtl/pc_ir_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_ir_fetch_unit
// Description : Fetch/decode-side register stage of a multicycle MIPS datapath.
//               Holds PC, IR, MDR and ALUOut, selects the unified-memory
//               address, applies next-PC selection and slices the IR into
//               instruction fields. Also keeps a saturating fetch counter and
//               a sticky illegal-opcode flag for debug.
// Ports       : clk, rst_n              - clock, async active-low reset
//               ir_write, pc_write,
//               branch, pc_src, iord    - control from the multicycle FSM
//               zero, alu_result        - ALU flag / combinational result
//               mem_rdata, mem_addr     - unified memory read data / address
//               pc, alu_out, mdr, ir    - architectural registers
//               opcode..imm             - decoded IR fields
//               fetch_count, illegal_op - debug status
// Revision    : 1.0 - initial release
// ============================================================================
module pc_ir_fetch_unit #(
    parameter int                 DATA_W   = 32,
    parameter logic [DATA_W-1:0]  RESET_PC = 32'h0000_0000,
    parameter int                 CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ir_write,
    input  logic              pc_write,
    input  logic              branch,
    input  logic [1:0]        pc_src,
    input  logic              iord,
    input  logic              zero,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] mdr,
    output logic [DATA_W-1:0] ir,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [5:0]        funct,
    output logic [15:0]       imm,
    output logic [CNT_W-1:0]  fetch_count,
    output logic              illegal_op
);

    localparam logic [1:0]       C_PCSRC_ALU  = 2'b00;
    localparam logic [1:0]       C_PCSRC_ALUO = 2'b01;
    localparam logic [1:0]       C_PCSRC_JUMP = 2'b10;
    localparam logic [CNT_W-1:0] C_CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] mdr_q;
    logic [DATA_W-1:0] alu_out_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ill_q, ill_d;
    logic              w_pc_en;
    logic              w_op_legal;
    logic [5:0]        w_new_op;

    assign w_pc_en  = pc_write | (branch & zero);
    assign w_new_op = mem_rdata[31:26];

    // Opcode support check is done on the incoming word so the flag sets on
    // the same edge the IR captures it.
    always_comb begin
        w_op_legal = 1'b0;
        case (w_new_op)
            6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02: w_op_legal = 1'b1;
            default:                                  w_op_legal = 1'b0;
        endcase
    end

    // Next-PC selection. The jump target uses the pre-edge IR/PC; word
    // addressing means no <<2 on the 26-bit target.
    always_comb begin
        pc_d = pc_q;
        if (w_pc_en) begin
            case (pc_src)
                C_PCSRC_ALU:  pc_d = alu_result;
                C_PCSRC_ALUO: pc_d = alu_out_q;
                C_PCSRC_JUMP: pc_d = {pc_q[31:26], ir_q[25:0]};
                default:      pc_d = pc_q;
            endcase
        end
    end

    always_comb begin
        ir_d  = ir_q;
        cnt_d = cnt_q;
        ill_d = ill_q;
        if (ir_write) begin
            ir_d = mem_rdata;
            if (cnt_q != C_CNT_MAX) begin
                cnt_d = cnt_q + C_CNT_ONE;
            end
            if (!w_op_legal) begin
                ill_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            mdr_q     <= '0;
            alu_out_q <= '0;
            cnt_q     <= '0;
            ill_q     <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mdr_q     <= mem_rdata;
            alu_out_q <= alu_result;
            cnt_q     <= cnt_d;
            ill_q     <= ill_d;
        end
    end

    assign mem_addr    = iord ? alu_out_q : pc_q;
    assign pc          = pc_q;
    assign alu_out     = alu_out_q;
    assign mdr         = mdr_q;
    assign ir          = ir_q;
    assign opcode      = ir_q[31:26];
    assign rs          = ir_q[25:21];
    assign rt          = ir_q[20:16];
    assign rd          = ir_q[15:11];
    assign funct       = ir_q[5:0];
    assign imm         = ir_q[15:0];
    assign fetch_count = cnt_q;
    assign illegal_op  = ill_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_ir_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_ir_fetch_unit
// Description : Directed self-checking bench for pc_ir_fetch_unit. A second
//               instance with a 2-bit counter shares all inputs to exercise
//               counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_ir_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        ir_write, pc_write, branch, iord, zero;
    logic [1:0]  pc_src;
    logic [31:0] alu_result, mem_rdata;

    logic [31:0] mem_addr, pc, alu_out, mdr, ir;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [15:0] fetch_count;
    logic        illegal_op;

    logic [31:0] s_mem_addr, s_pc, s_alu_out, s_mdr, s_ir;
    logic [5:0]  s_opcode, s_funct;
    logic [4:0]  s_rs, s_rt, s_rd;
    logic [15:0] s_imm;
    logic [1:0]  s_fetch_count;
    logic        s_illegal_op;

    int n_checks = 0;
    int n_errors = 0;

    pc_ir_fetch_unit #(.DATA_W(32), .RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .ir_write(ir_write), .pc_write(pc_write),
        .branch(branch), .pc_src(pc_src), .iord(iord), .zero(zero),
        .alu_result(alu_result), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
        .pc(pc), .alu_out(alu_out), .mdr(mdr), .ir(ir), .opcode(opcode),
        .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm),
        .fetch_count(fetch_count), .illegal_op(illegal_op)
    );

    pc_ir_fetch_unit #(.DATA_W(32), .RESET_PC(32'h0000_0000), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .ir_write(ir_write), .pc_write(pc_write),
        .branch(branch), .pc_src(pc_src), .iord(iord), .zero(zero),
        .alu_result(alu_result), .mem_rdata(mem_rdata), .mem_addr(s_mem_addr),
        .pc(s_pc), .alu_out(s_alu_out), .mdr(s_mdr), .ir(s_ir), .opcode(s_opcode),
        .rs(s_rs), .rt(s_rt), .rd(s_rd), .funct(s_funct), .imm(s_imm),
        .fetch_count(s_fetch_count), .illegal_op(s_illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ir_write = 1'b0; pc_write = 1'b0; branch = 1'b0; iord = 1'b0;
        zero = 1'b0; pc_src = 2'b00; alu_result = '0; mem_rdata = '0;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Dirty every register, then reset mid-cycle.
        ir_write = 1'b1; mem_rdata = 32'hFC00_0000;
        pc_write = 1'b1; alu_result = 32'h0000_0040;
        tick();
        check("pre_reset_pc", pc, 32'h40);
        check("pre_reset_ill", {31'd0, illegal_op}, 32'd1);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_pc", pc, 32'h0);
        check("rst_ir", ir, 32'h0);
        check("rst_cnt", {16'd0, fetch_count}, 32'd0);
        check("rst_ill", {31'd0, illegal_op}, 32'd0);
        check("rst_alu_out", alu_out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Fetch: IR load and PC+1 on the same edge.
        ir_write = 1'b1; pc_write = 1'b1; pc_src = 2'b00; iord = 1'b0;
        mem_rdata = 32'h8C22_0004; alu_result = 32'h1;
        #1;
        check("fetch_mem_addr", mem_addr, 32'h0);
        tick();
        check("fetch_ir", ir, 32'h8C22_0004);
        check("fetch_opcode", {26'd0, opcode}, 32'h23);
        check("fetch_rs", {27'd0, rs}, 32'd1);
        check("fetch_rt", {27'd0, rt}, 32'd2);
        check("fetch_imm", {16'd0, imm}, 32'h4);
        check("fetch_pc", pc, 32'h1);
        check("fetch_cnt", {16'd0, fetch_count}, 32'd1);
        check("fetch_mdr", mdr, 32'h8C22_0004);
        check("fetch_ill", {31'd0, illegal_op}, 32'd0);
        check("sat_cnt_1", {30'd0, s_fetch_count}, 32'd1);

        // Remaining supported opcodes must not raise the flag.
        pc_write = 1'b0;
        mem_rdata = 32'hAC00_0000; tick();
        check("sw_ill", {31'd0, illegal_op}, 32'd0);
        mem_rdata = 32'h1000_0000; tick();
        check("beq_ill", {31'd0, illegal_op}, 32'd0);
        check("sat_cnt_3", {30'd0, s_fetch_count}, 32'd3);
        mem_rdata = 32'h2000_1234; tick();
        check("addi_ill", {31'd0, illegal_op}, 32'd0);
        check("addi_rd", {27'd0, rd}, 32'd2);
        check("cnt_4", {16'd0, fetch_count}, 32'd4);
        check("sat_cnt_hold", {30'd0, s_fetch_count}, 32'd3);
        ir_write = 1'b0;

        // Branch via ALUOut.
        alu_result = 32'h10; tick();
        check("alu_out_load", alu_out, 32'h10);
        alu_result = 32'h99; pc_src = 2'b01; branch = 1'b1; zero = 1'b1;
        tick();
        check("beq_taken_pc", pc, 32'h10);
        alu_result = 32'h55; zero = 1'b0;
        tick();
        check("beq_not_taken_pc", pc, 32'h10);
        branch = 1'b0; pc_write = 1'b1; pc_src = 2'b11;
        tick();
        check("pcsrc11_hold", pc, 32'h10);
        pc_write = 1'b0; pc_src = 2'b00; alu_result = 32'h77;
        tick();
        check("pc_en0_hold", pc, 32'h10);

        // Jump.
        pc_write = 1'b1; pc_src = 2'b00; alu_result = 32'h0400_0005;
        ir_write = 1'b1; mem_rdata = 32'h0800_0040;
        tick();
        check("jmp_setup_pc", pc, 32'h0400_0005);
        check("jmp_opcode", {26'd0, opcode}, 32'h02);
        ir_write = 1'b0; mem_rdata = 32'hFFFF_FFFF; pc_src = 2'b10;
        tick();
        check("jmp_pc", pc, 32'h0400_0040);
        check("jmp_ir_hold", ir, 32'h0800_0040);
        // Jump and IR load on one edge: target comes from the old IR.
        ir_write = 1'b1; mem_rdata = 32'h0800_0123;
        tick();
        check("jmp_old_ir_pc", pc, 32'h0400_0040);
        check("jmp_new_ir", ir, 32'h0800_0123);
        pc_write = 1'b0;

        // Illegal opcode is sticky.
        mem_rdata = 32'hFC00_0000; tick();
        check("ill_set", {31'd0, illegal_op}, 32'd1);
        mem_rdata = 32'h0000_0020; tick();
        check("ill_sticky", {31'd0, illegal_op}, 32'd1);
        check("rtype_opcode", {26'd0, opcode}, 32'h00);
        check("rtype_funct", {26'd0, funct}, 32'h20);
        check("cnt_8", {16'd0, fetch_count}, 32'd8);
        check("sat_cnt_final", {30'd0, s_fetch_count}, 32'd3);
        ir_write = 1'b0;

        // Address mux.
        alu_result = 32'h24; tick();
        iord = 1'b1; #1;
        check("iord1_addr", mem_addr, 32'h24);
        iord = 1'b0; #1;
        check("iord0_addr", mem_addr, 32'h0400_0040);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_ir_fetch_unit.md
Name: pc_ir_fetch_unit

Overview:
- Fetch/decode-side register stage of the multicycle MIPS datapath, directly upstream of the multicycle control FSM.
- Holds PC, Instruction Register (IR), Memory Data Register (MDR) and ALUOut.
- Selects the unified-memory address (IorD), applies next-PC selection (PCSrc, PCWrite, branch·zero), and feeds the decoded opcode and instruction fields to the FSM and register file.
- Also keeps a retired-fetch counter and a sticky illegal-opcode flag for debug.

Parameters:
- DATA_W, 32, datapath/instruction width (fixed at 32 for MIPS field slicing).
- RESET_PC, 32'h0000_0000, PC value after reset.
- CNT_W, 16, width of the fetch counter.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- ir_write  in  1  load IR from mem_rdata (FSM IRWrite).
- pc_write  in  1  unconditional PC update (FSM PCWrite).
- branch  in  1  conditional PC update enable (FSM branch).
- pc_src  in  2  next-PC select: 00 alu_result, 01 alu_out, 10 jump target, 11 hold.
- iord  in  1  memory address select: 0 PC, 1 ALUOut.
- zero  in  1  ALU zero flag.
- alu_result  in  32  combinational ALU output.
- mem_rdata  in  32  unified memory read data.
- mem_addr  out  32  unified memory address.
- pc  out  32  current PC register.
- alu_out  out  32  ALUOut register.
- mdr  out  32  MDR register.
- ir  out  32  instruction register.
- opcode  out  6  ir[31:26].
- rs  out  5  ir[25:21].
- rt  out  5  ir[20:16].
- rd  out  5  ir[15:11].
- funct  out  6  ir[5:0].
- imm  out  16  ir[15:0].
- fetch_count  out  CNT_W  number of IR loads since reset, saturating.
- illegal_op  out  1  sticky: an IR load captured an unsupported opcode.

Behaviour:
Reset (rst_n low, asynchronous, effective immediately):
- pc=RESET_PC; ir=0; mdr=0; alu_out=0; fetch_count=0; illegal_op=0.
- Reset asserted mid-instruction discards all state; the first rising edge after release behaves as normal operation.

Every rising clk edge:
- alu_out <= alu_result (unconditional).
- mdr <= mem_rdata (unconditional).

IR load:
- On ir_write=1: ir <= mem_rdata, else hold.
- Field outputs are pure combinational slices of the registered ir (0-cycle from ir, 1-cycle from mem_rdata).

PC update:
- pc_en = pc_write | (branch & zero).
- When pc_en=1:
  - pc_src=00 → pc <= alu_result.
  - pc_src=01 → pc <= alu_out.
  - pc_src=10 → pc <= {pc[31:26], ir[25:0]}. Word addressing: PC advances by 1 per instruction, so there is no <<2.
  - pc_src=11 → pc holds.
- When pc_en=0: pc holds regardless of pc_src.
- branch=1 with zero=0 and pc_write=0: no update (branch not taken).

Memory address:
- mem_addr = iord ? alu_out : pc (combinational, no latency).

Fetch counter:
- Increments by 1 on each edge with ir_write=1.
- Saturates at 2^CNT_W−1; no wrap.

Illegal opcode:
- Supported opcodes: 6'h00 (R-type), 6'h23 (LW), 6'h2B (SW), 6'h04 (BEQ), 6'h08 (ADDI), 6'h02 (J).
- On ir_write=1 with mem_rdata[31:26] not in that set, illegal_op <= 1 on the same edge the IR is loaded.
- Sticky until rst_n; later legal loads do not clear it.

Simultaneous events:
- ir_write and pc_write in the same cycle (fetch state): both registers update on the same edge.
- The jump target uses the pre-edge ir and pc values.
- No internal FSM; the block is sequenced entirely by the control FSM outputs.

Test Plan:
1. Reset: drive rst_n=0 mid-cycle with pc=0x40 → pc=0, ir=0, fetch_count=0, illegal_op=0 immediately, without waiting for a clock edge.
2. Fetch: ir_write=1, pc_write=1, pc_src=00, iord=0, mem_rdata=0x8C220004, alu_result=1 → after edge: ir=0x8C220004, opcode=0x23, rs=1, rt=2, imm=0x0004, pc=1, fetch_count=1; mem_addr was 0 during the cycle.
3. Branch: alu_out preloaded 0x10, pc_src=01, branch=1. With zero=1 → pc=0x10. Repeat with zero=0 → pc unchanged.
4. Jump: pc=0x0400_0005, ir=0x08000040, pc_src=10, pc_write=1 → pc=0x0400_0040.
5. Illegal opcode: ir_write=1 with mem_rdata=0xFC000000 → illegal_op=1 next edge. Then load 0x00000020 → illegal_op stays 1, opcode=0x00, funct=0x20.
6. Address mux/saturation: iord=1 with alu_out=0x24 → mem_addr=0x24 same cycle. With CNT_W=2, five ir_write pulses → fetch_count=3.
